// File: rtl/rv_lsu_multicycle.sv
// rv_lsu_multicycle: multicycle load/store unit between execute and data bus.
// Ports: clk, rst (sync, active-low); req_* request in (valid/ready);
//   resp_* one-cycle response out; mem_* aligned bus access with byte
//   enables and a wait-state handshake (mem_ack, mem_rd_data).
module rv_lsu_multicycle #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_data,
   output logic [1:0]        resp_err,
   output logic              mem_req,
   output logic [XLEN-1:0]   mem_addr,
   output logic              mem_wr_ena,
   output logic [XLEN/8-1:0] mem_be,
   output logic [XLEN-1:0]   mem_wr_data,
   input  logic              mem_ack,
   input  logic [XLEN-1:0]   mem_rd_data
);

   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);
   // Counter only needs to reach TIMEOUT-1; the last count ends BUS.
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_ALIGN = 2'b01;
   localparam logic [1:0] ERR_TMO   = 2'b10;
   localparam logic [1:0] ERR_ILL   = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUS,
      S_RESP
   } state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic [1:0]        err_q, err_d;

   logic [OW-1:0]     off;
   logic [NB-1:0]     lane_mask;
   logic [NB-1:0]     be_lane;
   logic [XLEN-1:0]   wdata_lane;
   logic [XLEN-1:0]   rd_shift;
   logic [XLEN-1:0]   ld_ext;
   logic              in_bus;
   logic              in_resp;

   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      case (f3)
         3'b000, 3'b001, 3'b010: ok = 1'b1;
         3'b011:                 ok = (XLEN == 64);
         3'b100, 3'b101:         ok = !we;
         3'b110:                 ok = !we && (XLEN == 64);
         default:                ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] a);
      logic m;
      m = 1'b0;
      case (f3[1:0])
         2'b01:   m = a[0];
         2'b10:   m = |a[1:0];
         2'b11:   m = |a[2:0];
         default: m = 1'b0;
      endcase
      return m;
   endfunction

   // Lane steering from the latched request only, so nothing on the
   // request side reaches the bus outputs combinationally.
   always_comb begin
      off       = addr_q[OW-1:0];
      lane_mask = '0;
      case (f3_q[1:0])
         2'b00:   lane_mask = NB'(8'h01);
         2'b01:   lane_mask = NB'(8'h03);
         2'b10:   lane_mask = NB'(8'h0F);
         default: lane_mask = NB'(8'hFF);
      endcase
      be_lane    = lane_mask << off;
      wdata_lane = wdata_q << {off, 3'b000};
      rd_shift   = mem_rd_data >> {off, 3'b000};
   end

   always_comb begin
      ld_ext = '0;
      case (f3_q)
         3'b000:  ld_ext = XLEN'($signed(rd_shift[7:0]));
         3'b001:  ld_ext = XLEN'($signed(rd_shift[15:0]));
         3'b010:  ld_ext = XLEN'($signed(rd_shift[31:0]));
         3'b011:  ld_ext = rd_shift;
         3'b100:  ld_ext = XLEN'(rd_shift[7:0]);
         3'b101:  ld_ext = XLEN'(rd_shift[15:0]);
         3'b110:  ld_ext = XLEN'(rd_shift[31:0]);
         default: ld_ext = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = '0;
               rdata_d = '0;
               if (!f3_legal(req_we, req_funct3)) begin
                  err_d   = ERR_ILL;
                  state_d = S_RESP;
               end else if (misaligned(req_funct3, req_addr[2:0])) begin
                  err_d   = ERR_ALIGN;
                  state_d = S_RESP;
               end else begin
                  err_d   = ERR_OK;
                  state_d = S_BUS;
               end
            end
         end
         S_BUS: begin
            // Ack is checked first so it wins over a same-cycle timeout.
            if (mem_ack) begin
               rdata_d = we_q ? '0 : ld_ext;
               err_d   = ERR_OK;
               state_d = S_RESP;
            end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
               rdata_d = '0;
               err_d   = ERR_TMO;
               state_d = S_RESP;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Bus and response outputs are gated by state so they read as zero
   // whenever the unit is not in the matching phase.
   assign in_bus      = (state_q == S_BUS);
   assign in_resp     = (state_q == S_RESP);
   assign req_ready   = (state_q == S_IDLE) && rst;
   assign mem_req     = in_bus;
   assign mem_addr    = in_bus ? {addr_q[XLEN-1:OW], {OW{1'b0}}} : '0;
   assign mem_wr_ena  = in_bus && we_q;
   assign mem_be      = in_bus ? be_lane : '0;
   assign mem_wr_data = (in_bus && we_q) ? wdata_lane : '0;
   assign resp_valid  = in_resp;
   assign resp_data   = in_resp ? rdata_q : '0;
   assign resp_err    = in_resp ? err_q : 2'b00;

endmodule

// File: tb/tb_rv_lsu_multicycle.sv
// tb_rv_lsu_multicycle: table vectors, corner sequences and random
// transactions for 32- and 64-bit LSU instances against a reference model.
module tb_rv_lsu_multicycle;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sel64 = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        mem_ack = 1'b0;
   logic [63:0] mem_rd_data = '0;

   logic        v32, v64;
   logic        r32_ready, r32_rv, r32_mreq, r32_wena;
   logic [31:0] r32_data, r32_maddr, r32_mwd;
   logic [1:0]  r32_err;
   logic [3:0]  r32_be;
   logic        r64_ready, r64_rv, r64_mreq, r64_wena;
   logic [63:0] r64_data, r64_maddr, r64_mwd;
   logic [1:0]  r64_err;
   logic [7:0]  r64_be;

   logic        o_ready, o_rv, o_mreq, o_wena;
   logic [63:0] o_data, o_maddr, o_mwd, o_be;
   logic [1:0]  o_err;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   assign v32 = req_valid && !sel64;
   assign v64 = req_valid && sel64;

   rv_lsu_multicycle #(.XLEN(32), .TIMEOUT(TMO)) dut32 (
      .clk(clk), .rst(rst),
      .req_valid(v32), .req_ready(r32_ready),
      .req_we(req_we), .req_funct3(req_funct3),
      .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
      .resp_valid(r32_rv), .resp_data(r32_data), .resp_err(r32_err),
      .mem_req(r32_mreq), .mem_addr(r32_maddr), .mem_wr_ena(r32_wena),
      .mem_be(r32_be), .mem_wr_data(r32_mwd),
      .mem_ack(mem_ack), .mem_rd_data(mem_rd_data[31:0])
   );

   rv_lsu_multicycle #(.XLEN(64), .TIMEOUT(TMO)) dut64 (
      .clk(clk), .rst(rst),
      .req_valid(v64), .req_ready(r64_ready),
      .req_we(req_we), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(r64_rv), .resp_data(r64_data), .resp_err(r64_err),
      .mem_req(r64_mreq), .mem_addr(r64_maddr), .mem_wr_ena(r64_wena),
      .mem_be(r64_be), .mem_wr_data(r64_mwd),
      .mem_ack(mem_ack), .mem_rd_data(mem_rd_data)
   );

   always_comb begin
      o_ready = sel64 ? r64_ready : r32_ready;
      o_rv    = sel64 ? r64_rv : r32_rv;
      o_mreq  = sel64 ? r64_mreq : r32_mreq;
      o_wena  = sel64 ? r64_wena : r32_wena;
      o_err   = sel64 ? r64_err : r32_err;
      o_data  = sel64 ? r64_data : {32'd0, r32_data};
      o_maddr = sel64 ? r64_maddr : {32'd0, r32_maddr};
      o_mwd   = sel64 ? r64_mwd : {32'd0, r32_mwd};
      o_be    = sel64 ? {56'd0, r64_be} : {60'd0, r32_be};
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Reference model: byte-level arithmetic over the load/store rules.
   task automatic model(input bit s64, input bit we, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] rd,
                        output logic [1:0] err, output logic [63:0] data,
                        output logic [63:0] maddr, output logic [63:0] be,
                        output logic [63:0] mwd);
      int nbus, n, off;
      logic [63:0] xm, v, sz;
      bit legal;
      nbus = s64 ? 8 : 4;
      n    = 1 << f3[1:0];
      xm   = s64 ? '1 : 64'hFFFF_FFFF;
      off  = int'(a % 64'(nbus));
      if (we) legal = (f3 <= 3'd2) || (s64 && f3 == 3'd3);
      else legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
                   (s64 && (f3 inside {3'd3, 3'd6}));
      err = 2'b00; data = '0; maddr = '0; be = '0; mwd = '0;
      if (!legal) err = 2'b11;
      else if (a % 64'(n) != 0) err = 2'b01;
      else begin
         maddr = (a & xm) - 64'(off);
         be    = ((64'd1 << n) - 1) << off;
         if (we) mwd = ((wd & xm) << (8 * off)) & xm;
         else begin
            v = (rd & xm) >> (8 * off);
            if (n < 8) begin
               sz = (64'd1 << (8 * n)) - 1;
               v  = v & sz;
               if (!f3[2] && v[8*n-1]) v = v | ~sz;
            end
            data = v & xm;
         end
      end
   endtask

   // One transaction from a negedge with the unit idle; ends on the
   // negedge after the response, checking ready is back.
   task automatic xact(input string tag, input bit s64, input bit we,
                       input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input logic [63:0] rd,
                       input int ackn, input logic [1:0] e_err,
                       input logic [63:0] e_data, input logic [63:0] e_maddr,
                       input logic [63:0] e_be, input logic [63:0] e_mwd,
                       input int e_nreq);
      int nreq;
      bit got;
      sel64 = s64;
      #1;
      chk({tag, ".ready"}, 64'(o_ready), 64'd1);
      req_we = we; req_funct3 = f3; req_addr = a;
      req_wdata = wd; mem_rd_data = rd; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      nreq = 0;
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         chk({tag, ".active"}, 64'(o_mreq | o_rv), 64'd1);
         if (!(o_mreq | o_rv)) break;
         if (o_rv) begin
            got = 1'b1;
            chk({tag, ".err"}, 64'(o_err), 64'(e_err));
            chk({tag, ".data"}, o_data, e_data);
            chk({tag, ".nreq"}, 64'(nreq), 64'(e_nreq));
            chk({tag, ".req_drop"}, 64'(o_mreq), 64'd0);
         end else begin
            nreq++;
            chk({tag, ".maddr"}, o_maddr, e_maddr);
            chk({tag, ".be"}, o_be, e_be);
            chk({tag, ".wena"}, 64'(o_wena), 64'(we));
            chk({tag, ".mwd"}, o_mwd, e_mwd);
            if (nreq == ackn) mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
         end
      end
      chk({tag, ".resp_seen"}, 64'(got), 64'd1);
      if (got) begin
         @(negedge clk);
         chk({tag, ".pulse1"}, 64'(o_rv), 64'd0);
         chk({tag, ".ready_back"}, 64'(o_ready), 64'd1);
      end
   endtask

   typedef struct {
      bit          s64;
      bit          we;
      logic [2:0]  f3;
      logic [63:0] a;
      logic [63:0] wd;
      logic [63:0] rd;
      int          ackn;
      logic [1:0]  err;
      logic [63:0] data;
      logic [63:0] maddr;
      logic [63:0] be;
      logic [63:0] mwd;
      int          nreq;
   } vec_t;

   vec_t tbl[12];

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  m_err;
      logic [63:0] m_data, m_maddr, m_be, m_mwd;
      int          m_nreq;
      tbl[0]  = '{0, 0, 3'd0, 64'h103, 64'h0, 64'h80FF_1234, 1,
                  2'b00, 64'hFFFF_FF80, 64'h100, 64'h8, 64'h0, 1};
      tbl[1]  = '{0, 0, 3'd4, 64'h103, 64'h0, 64'h80FF_1234, 1,
                  2'b00, 64'h80, 64'h100, 64'h8, 64'h0, 1};
      tbl[2]  = '{0, 1, 3'd1, 64'h22, 64'hBEEF, 64'h0, 3,
                  2'b00, 64'h0, 64'h20, 64'hC, 64'hBEEF_0000, 3};
      tbl[3]  = '{0, 0, 3'd2, 64'h102, 64'h0, 64'h0, 1,
                  2'b01, 64'h0, 64'h0, 64'h0, 64'h0, 0};
      tbl[4]  = '{0, 0, 3'd3, 64'h100, 64'h0, 64'h0, 1,
                  2'b11, 64'h0, 64'h0, 64'h0, 64'h0, 0};
      tbl[5]  = '{0, 0, 3'd2, 64'h40, 64'h0, 64'h1234_5678, 0,
                  2'b10, 64'h0, 64'h40, 64'hF, 64'h0, 4};
      tbl[6]  = '{0, 0, 3'd2, 64'h40, 64'h0, 64'h1234_5678, 4,
                  2'b00, 64'h1234_5678, 64'h40, 64'hF, 64'h0, 4};
      tbl[7]  = '{1, 0, 3'd6, 64'h1004, 64'h0, 64'h8000_0001_DEAD_BEEF, 2,
                  2'b00, 64'h8000_0001, 64'h1000, 64'hF0, 64'h0, 2};
      tbl[8]  = '{1, 0, 3'd3, 64'h1004, 64'h0, 64'h0, 1,
                  2'b01, 64'h0, 64'h0, 64'h0, 64'h0, 0};
      tbl[9]  = '{1, 1, 3'd3, 64'h2000, 64'h0123_4567_89AB_CDEF, 64'h0, 2,
                  2'b00, 64'h0, 64'h2000, 64'hFF, 64'h0123_4567_89AB_CDEF, 2};
      tbl[10] = '{0, 1, 3'd4, 64'h10, 64'h0, 64'h0, 1,
                  2'b11, 64'h0, 64'h0, 64'h0, 64'h0, 0};
      tbl[11] = '{1, 0, 3'd2, 64'h1004, 64'h0, 64'h8000_0001_DEAD_BEEF, 1,
                  2'b00, 64'hFFFF_FFFF_8000_0001, 64'h1000, 64'hF0, 64'h0, 1};

      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst.r32", {60'd0, r32_ready, r32_rv, r32_mreq, r32_wena}, 64'd0);
      chk("rst.r32b", {r32_data, r32_maddr}, 64'd0);
      chk("rst.r32c", {26'd0, r32_err, r32_be, r32_mwd}, 64'd0);
      chk("rst.r64", {60'd0, r64_ready, r64_rv, r64_mreq, r64_wena}, 64'd0);
      chk("rst.r64b", r64_data | r64_maddr | r64_mwd, 64'd0);
      chk("rst.r64c", {54'd0, r64_err, r64_be}, 64'd0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         xact($sformatf("tbl%0d", i), tbl[i].s64, tbl[i].we, tbl[i].f3,
              tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].ackn, tbl[i].err,
              tbl[i].data, tbl[i].maddr, tbl[i].be, tbl[i].mwd, tbl[i].nreq);
      end

      // Reset during a bus access: no response, bus dropped, recovers.
      sel64 = 1'b0;
      req_we = 1'b0; req_funct3 = 3'd2; req_addr = 64'h80;
      mem_rd_data = 64'h0; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("mrst.bus", 64'(o_mreq), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mrst.mreq", 64'(o_mreq), 64'd0);
      chk("mrst.rv", 64'(o_rv), 64'd0);
      chk("mrst.ready_lo", 64'(o_ready), 64'd0);
      rst = 1'b1;
      #1;
      chk("mrst.ready_hi", 64'(o_ready), 64'd1);
      repeat (2) begin
         @(negedge clk);
         chk("mrst.no_resp", 64'(o_rv | o_mreq), 64'd0);
      end
      xact("mrst.lw", 0, 0, 3'd2, 64'h84, 64'h0, 64'hCAFE_F00D, 2,
           2'b00, 64'hCAFE_F00D, 64'h84, 64'hF, 64'h0, 2);

      for (int i = 0; i < 80; i++) begin
         bit          s64, we;
         logic [2:0]  f3;
         logic [63:0] a, wd, rd;
         int          ackn;
         s64  = 1'($urandom_range(0, 1));
         we   = 1'($urandom_range(0, 1));
         f3   = 3'($urandom_range(0, 7));
         a    = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f3[1:0]) - 1);
         wd   = {$urandom, $urandom};
         rd   = {$urandom, $urandom};
         ackn = $urandom_range(0, TMO + 1);
         model(s64, we, f3, a, wd, rd, m_err, m_data, m_maddr, m_be, m_mwd);
         m_nreq = 0;
         if (m_err == 2'b00) begin
            if (ackn == 0 || ackn > TMO) begin
               m_err  = 2'b10;
               m_data = '0;
               m_nreq = TMO;
            end else begin
               m_nreq = ackn;
            end
         end
         xact($sformatf("rnd%0d", i), s64, we, f3, a, wd, rd, ackn,
              m_err, m_data, m_maddr, m_be, m_mwd, m_nreq);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rv_lsu_multicycle.md
# rv_lsu_multicycle

Parametrised multicycle load/store unit that sits between the multicycle RV core's execute stage and the data-memory bus. It takes one load or store request per transaction and does the following:
- generates an aligned bus access with byte enables;
- waits a variable number of cycles for the memory acknowledge, bounded by a timeout;
- returns sign- or zero-extended load data, or an error code.

It generalises the core's single-cycle, word-only memory access to byte, halfword, word and (XLEN=64) doubleword accesses over a wait-state handshake.

## Interface
Parameters:
- XLEN, 32, data/address width; legal values 32 or 64.
- TIMEOUT, 16, bus cycles to wait for mem_ack before flagging an error; 0 disables the timeout.

Ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on rising edge.
- rst, in, 1, synchronous, active-low reset: rst=0 at a rising edge resets the block.
- req_valid, in, 1, request present.
- req_ready, out, 1, unit idle; request accepted on a rising edge with req_valid & req_ready.
- req_we, in, 1, 1=store, 0=load.
- req_funct3, in, 3, RISC-V load/store funct3.
- req_addr, in, XLEN, byte address (rs1+imm, already computed).
- req_wdata, in, XLEN, store data (rs2).
- resp_valid, out, 1, one-cycle pulse; response complete.
- resp_data, out, XLEN, extended load data; 0 for stores and errors.
- resp_err, out, 2, 00 ok, 01 misaligned, 10 timeout, 11 illegal funct3.
- mem_req, out, 1, bus access in progress.
- mem_addr, out, XLEN, req_addr with low log2(XLEN/8) bits cleared.
- mem_wr_ena, out, 1, store access.
- mem_be, out, XLEN/8, byte enables.
- mem_wr_data, out, XLEN, lane-shifted store data.
- mem_ack, in, 1, bus completes the access this cycle; mem_rd_data valid.
- mem_rd_data, in, XLEN, read data.

## Operation
- States: IDLE, BUS, RESP. req_ready=1 only in IDLE with rst=1.
- IDLE: on accept, latch we, funct3, addr, wdata. Check in order:
  - illegal funct3 → err 11;
  - else misaligned → err 01.
  - Either error → RESP with no bus activity.
  - Otherwise → BUS, with mem_* driven from the latched values.
- Legal funct3:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; XLEN=64 adds 011 LD and 110 LWU.
  - stores: 000 SB, 001 SH, 010 SW; XLEN=64 adds 011 SD.
  - Everything else is illegal.
- Misaligned: size 2 with addr[0]≠0; size 4 with addr[1:0]≠0; size 8 with addr[2:0]≠0. Byte accesses are never misaligned.
- Lane offset off = addr[log2(XLEN/8)-1:0]. Lane mask is 1, 3, 0xF or 0xFF by size; mem_be = mask << off.
- Stores: mem_wr_data = req_wdata << (8*off). Loads: mem_be identical, mem_wr_ena=0, mem_wr_data=0.
- BUS: mem_req and all mem_* held stable until mem_ack.
  - On mem_ack: capture (mem_rd_data >> 8*off), truncate to size, sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU) to XLEN; → RESP with err 00.
  - Store acks return resp_data=0.
- Timeout: a counter clears on entry to BUS and increments each BUS cycle without ack. When it reaches TIMEOUT → RESP with err 10, mem_req dropped, bus access abandoned.
- If mem_ack and timeout coincide, ack wins.
- RESP: resp_valid=1 for exactly one cycle, resp_data/resp_err valid with it; → IDLE. There is no response backpressure.
- mem_ack outside BUS is ignored.

## Timing
- Reset values:
  - state=IDLE; counter=0;
  - req_ready=0 while rst=0;
  - resp_valid=0, resp_data=0, resp_err=00;
  - mem_req=0, mem_wr_ena=0, mem_be=0, mem_addr=0, mem_wr_data=0.
- Reset mid-transaction (BUS or RESP): at that edge the block returns to IDLE, mem_req=0 from the next cycle, and no resp_valid is issued.
- Latencies (accept edge = cycle N):
  - Error path: resp_valid in cycle N+1.
  - Bus path: mem_req high from cycle N+1; mem_ack sampled at cycle M ≥ N+1 gives resp_valid in cycle M+1. Minimum 2 cycles.
  - Timeout: mem_req is high for exactly TIMEOUT cycles; resp_valid follows in the next cycle.
- req_ready returns high the cycle after resp_valid; back-to-back throughput is one transaction per 3 cycles minimum.
- All outputs are registered or decoded from state only; there is no combinational path from req_* or mem_ack to any output.

## Test plan
- LB/LBU, XLEN=32: addr=0x103, mem_rd_data=0x80FF_1234 → mem_addr=0x100, mem_be=1000b. LB gives resp_data=0xFFFF_FF80; LBU gives 0x0000_0080; err 00.
- SH with wait states: addr=0x22, wdata=0x0000_BEEF, ack after 3 cycles → mem_be=1100b, mem_wr_data=0xBEEF_0000, mem_wr_ena=1 held 3 cycles, resp_valid 1 cycle later with err 00.
- Misaligned/illegal: LW addr=0x102 → resp_err 01 at N+1, mem_req never rises. funct3=011 with XLEN=32 → err 11.
- Timeout, TIMEOUT=4, no ack: mem_req high exactly 4 cycles, then resp_err 10, resp_data 0. Repeat with ack in the 4th cycle → err 00 (ack wins).
- XLEN=64: LWU addr=0x…04, mem_rd_data=0x8000_0001_xxxx_xxxx → resp_data=0x0000_0000_8000_0001; LD addr=0x…04 → err 01.
- Reset mid-BUS: assert rst=0 for one edge during a load → no resp_valid, mem_req=0 next cycle, req_ready=1 once rst=1; a following LW completes normally.
